// File: rtl/alu_result_buffer.sv
// FWFT capture FIFO for ALU results: snapshots {sel, c, carry, mul_out} on in_valid
// and hands them to a slower consumer over a valid/ready handshake.
module alu_result_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       sel,
  input  logic [3:0]       c,
  input  logic             carry,
  input  logic [7:0]       mul_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_sel,
  output logic [3:0]       out_c,
  output logic             out_carry,
  output logic [7:0]       out_mul,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             drop,
  output logic [15:0]      op_seen
);

  localparam logic [PTR_W:0] full_count_c = (PTR_W + 1)'(DEPTH);

  logic [16:0]      mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             full_r;
  logic             valid_r;
  logic             drop_r;
  logic [15:0]      op_seen_r;

  logic             push_s;
  logic             pop_s;
  logic [PTR_W:0]   next_count_s;
  logic [16:0]      head_s;

  // Handshake decode and next occupancy; a full buffer still accepts when the head leaves.
  always_comb begin
    pop_s        = 1'b0;
    push_s       = 1'b0;
    next_count_s = count_r;
    pop_s        = valid_r & out_ready;
    push_s       = in_valid & (~full_r | pop_s);
    case ({push_s, pop_s})
      2'b10:   next_count_s = count_r + {{PTR_W{1'b0}}, 1'b1};
      2'b01:   next_count_s = count_r - {{PTR_W{1'b0}}, 1'b1};
      default: next_count_s = count_r;
    endcase
  end

  // Pointer, occupancy and sticky status registers; full/valid are kept registered alongside count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      count_r   <= {(PTR_W + 1){1'b0}};
      full_r    <= 1'b0;
      valid_r   <= 1'b0;
      drop_r    <= 1'b0;
      op_seen_r <= 16'h0000;
    end else begin
      if (push_s) begin
        wr_ptr_r           <= wr_ptr_r + {{(PTR_W - 1){1'b0}}, 1'b1};
        op_seen_r[sel]     <= 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PTR_W - 1){1'b0}}, 1'b1};
      end
      if (in_valid && !push_s) begin
        drop_r <= 1'b1;
      end
      count_r <= next_count_s;
      full_r  <= (next_count_s == full_count_c);
      valid_r <= (next_count_s != {(PTR_W + 1){1'b0}});
    end
  end

  // Entry storage; deliberately not reset, contents are only meaningful while valid.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_r[wr_ptr_r] <= {sel, c, carry, mul_out};
    end
  end

  assign head_s    = mem_r[rd_ptr_r];
  assign out_sel   = head_s[16:13];
  assign out_c     = head_s[12:9];
  assign out_carry = head_s[8];
  assign out_mul   = head_s[7:0];
  assign out_valid = valid_r;
  assign in_ready  = ~full_r;
  assign full      = full_r;
  assign count     = count_r;
  assign drop      = drop_r;
  assign op_seen   = op_seen_r;

  alu_result_buffer_checker #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_checker (
    .clk       (clk),
    .rst       (rst),
    .count     (count_r),
    .full      (full_r),
    .out_valid (valid_r)
  );

endmodule

// Occupancy invariants for alu_result_buffer.
module alu_result_buffer_checker #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input logic           clk,
  input logic           rst,
  input logic [PTR_W:0] count,
  input logic           full,
  input logic           out_valid
);

  localparam logic [PTR_W:0] full_count_c = (PTR_W + 1)'(DEPTH);

  a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= full_count_c);
  a_full_implies_valid: assert property (@(posedge clk) disable iff (rst) !(full && !out_valid));

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed self-checking bench for alu_result_buffer (DEPTH=4).
module tb_alu_result_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] sel;
  logic [3:0] c;
  logic       carry;
  logic [7:0] mul_out;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_sel;
  logic [3:0] out_c;
  logic       out_carry;
  logic [7:0] out_mul;
  logic [2:0] count;
  logic       full;
  logic       drop;
  logic [15:0] op_seen;

  int checks = 0;
  int failures = 0;

  alu_result_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .c(c), .carry(carry), .mul_out(mul_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sel(out_sel), .out_c(out_c), .out_carry(out_carry), .out_mul(out_mul),
    .count(count), .full(full), .drop(drop), .op_seen(op_seen)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    sel = 4'h0; c = 4'h0; carry = 1'b0; mul_out = 8'h00;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (drop !== 1'b0) begin failures++; $display("FAIL reset_drop got %b exp 0", drop); end
    checks++; if (op_seen !== 16'h0000) begin failures++; $display("FAIL reset_op_seen got %h exp 0000", op_seen); end
  endtask

  task automatic test_single_push();
    in_valid = 1'b1; sel = 4'h3; c = 4'hD; carry = 1'b1; mul_out = 8'h1E; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_out_valid got %b exp 1", out_valid); end
    checks++; if ({out_sel, out_c, out_carry, out_mul} !== {4'h3, 4'hD, 1'b1, 8'h1E})
      begin failures++; $display("FAIL single_head got %h/%h/%b/%h exp 3/d/1/1e", out_sel, out_c, out_carry, out_mul); end
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL single_count got %0d exp 1", count); end
    checks++; if (op_seen !== 16'h0008) begin failures++; $display("FAIL single_op_seen got %h exp 0008", op_seen); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL single_drain got count=%0d valid=%b exp 0/0", count, out_valid); end
  endtask

  task automatic fill_1_to_4();
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; sel = 4'(i); c = 4'(15 - i); carry = 1'(i); mul_out = 8'(i * 3);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_fill_overflow();
    do_reset();
    fill_1_to_4();
    checks++; if (full !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL fill_full got full=%b in_ready=%b exp 1/0", full, in_ready); end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_count got %0d exp 4", count); end
    in_valid = 1'b1; sel = 4'h5;
    tick();
    in_valid = 1'b0;
    checks++; if (drop !== 1'b1) begin failures++; $display("FAIL overflow_drop got %b exp 1", drop); end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL overflow_count got %0d exp 4", count); end
    checks++; if (op_seen[5] !== 1'b0) begin failures++; $display("FAIL overflow_op_seen5 got %b exp 0", op_seen[5]); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (out_valid !== 1'b1 || out_sel !== 4'(i) || out_c !== 4'(15 - i) || out_mul !== 8'(i * 3))
        begin failures++; $display("FAIL drain_head%0d got valid=%b sel=%h c=%h mul=%h", i, out_valid, out_sel, out_c, out_mul); end
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got count=%0d valid=%b exp 0/0", count, out_valid); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    fill_1_to_4();
    in_valid = 1'b1; sel = 4'h9; c = 4'h1; carry = 1'b0; mul_out = 8'h99; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL pushpop_count got %0d exp 4", count); end
    checks++; if (drop !== 1'b0) begin failures++; $display("FAIL pushpop_drop got %b exp 0", drop); end
    checks++; if (out_sel !== 4'h2) begin failures++; $display("FAIL pushpop_head got %h exp 2", out_sel); end
    for (int i = 0; i < 4; i++) begin
      logic [3:0] exp_sel;
      exp_sel = (i == 3) ? 4'h9 : 4'(i + 2);
      checks++; if (out_valid !== 1'b1 || out_sel !== exp_sel)
        begin failures++; $display("FAIL pushpop_drain%0d got valid=%b sel=%h exp 1/%h", i, out_valid, out_sel, exp_sel); end
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL pushpop_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_wrap_sweep();
    do_reset();
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL empty_pop got valid=%b count=%0d exp 0/0", out_valid, count); end
    for (int s = 1; s <= 15; s++) begin
      in_valid = 1'b1; sel = 4'(s); c = 4'(s); carry = 1'b0; mul_out = 8'(s * s);
      tick();
      checks++; if (out_valid !== 1'b1 || out_sel !== 4'(s) || out_mul !== 8'(s * s) || count !== 3'd1)
        begin failures++; $display("FAIL sweep%0d got valid=%b sel=%h mul=%h count=%0d", s, out_valid, out_sel, out_mul, count); end
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL sweep_final_count got %0d exp 0", count); end
    checks++; if (op_seen !== 16'hFFFE) begin failures++; $display("FAIL sweep_op_seen got %h exp fffe", op_seen); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_valid = 1'b1; sel = 4'h5;
    tick();
    in_valid = 1'b1; sel = 4'h5;
    tick();
    in_valid = 1'b1; sel = 4'h5;
    tick();
    in_valid = 1'b1; sel = 4'h5;
    tick();
    in_valid = 1'b1; sel = 4'h5;
    tick();
    checks++; if (drop !== 1'b1) begin failures++; $display("FAIL mid_pre_drop got %b exp 1", drop); end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; sel = 4'(10 + i);
      tick();
    end
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL mid_pre_count got %0d exp 3", count); end
    rst = 1'b1; in_valid = 1'b1; sel = 4'hE; out_ready = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst got count=%0d valid=%b exp 0/0", count, out_valid); end
    checks++; if (drop !== 1'b0 || op_seen !== 16'h0000) begin failures++; $display("FAIL mid_rst_sticky got drop=%b op_seen=%h exp 0/0000", drop, op_seen); end
    in_valid = 1'b1; sel = 4'h6; c = 4'h7; carry = 1'b1; mul_out = 8'h2A;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || {out_sel, out_c, out_carry, out_mul} !== {4'h6, 4'h7, 1'b1, 8'h2A} || count !== 3'd1)
      begin failures++; $display("FAIL mid_first_push got valid=%b sel=%h c=%h carry=%b mul=%h count=%0d", out_valid, out_sel, out_c, out_carry, out_mul, count); end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill_overflow();
    test_full_push_pop();
    test_wrap_sweep();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
Downstream capture stage for the 4-bit ALU. Each cycle that in_valid is high, it snapshots the ALU outputs (c, carry, mul_out) together with the opcode that produced them (sel) into a small FIFO. It presents entries in first-word-fall-through (FWFT) order to a consumer over a valid/ready handshake. It decouples the ALU sweep (one opcode per step) from a slower checker or logger.

Parameters:
DEPTH, 4, number of entries; power of two, minimum 2.
PTR_W, 2, pointer width; must equal log2(DEPTH).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  ALU result present this cycle.
in_ready  output  1  buffer can accept; equals !full.
sel  input  4  opcode that produced the result.
c  input  4  ALU result.
carry  input  1  ALU carry.
mul_out  input  8  ALU product.
out_valid  output  1  head entry valid; equals !empty.
out_ready  input  1  consumer takes the head entry.
out_sel  output  4  head opcode.
out_c  output  4  head result.
out_carry  output  1  head carry.
out_mul  output  8  head product.
count  output  PTR_W+1  current occupancy, 0..DEPTH.
full  output  1  count == DEPTH.
drop  output  1  sticky; a push was lost.
op_seen  output  16  sticky; bit k set once any entry with sel==k has been accepted.

Behaviour:
- Entry format: 17 bits, {sel, c, carry, mul_out}. Storage is a register array indexed by wr_ptr and rd_ptr, each PTR_W bits and wrapping modulo DEPTH.
- push = in_valid & (!full | pop).
- pop = out_valid & out_ready.
- On push: write the entry at wr_ptr, then wr_ptr+1.
- On pop: rd_ptr+1.
- count update: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Latency: an entry pushed at edge N appears on out_* with out_valid=1 after edge N. This is one cycle, with no extra read latency.
- out_* is driven from mem[rd_ptr] (combinational read of registered storage). When out_valid=0, out_* hold the last array contents and are don't-care; the bench must not check them.
- Full with simultaneous in_valid and pop: push is accepted, count stays DEPTH, and drop is not set.
- Full, in_valid=1, no pop: entry is discarded, drop is set to 1, and pointers and count are unchanged.
- Empty with out_ready=1: no pop occurs and rd_ptr is unchanged. There is no bypass: an empty buffer with in_valid does not present data in the same cycle.
- drop: set as above; cleared only by rst.
- op_seen: bit sel is set on every accepted push; cleared only by rst.
- Reset (synchronous, any cycle, including mid-stream with full or partial occupancy) sets wr_ptr=0, rd_ptr=0, count=0, full=0, out_valid=0, in_ready=1, drop=0, op_seen=0.
  - Array contents are not reset.
  - A push or pop coincident with rst is ignored.
- No state machine beyond the pointer/count datapath. Assertions are required:
  - count never exceeds DEPTH.
  - full and out_valid=0 are never both true.

Test Plan:
- Reset then idle: rst high 2 cycles, then low -> count=0, out_valid=0, in_ready=1, drop=0, op_seen=16'h0000.
- Single push: in_valid one cycle with sel=4'h3, c=4'hD, carry=1, mul_out=8'h1E, out_ready=0.
  - Next cycle: out_valid=1, out_sel=3, out_c=D, out_carry=1, out_mul=1E, count=1, op_seen=16'h0008.
- Fill and overflow: push sel=1,2,3,4 on consecutive cycles with out_ready=0 -> full=1, in_ready=0, count=4.
  - Fifth push sel=5 -> drop=1, count=4, op_seen bit5=0.
  - Then drain -> heads appear in order 1,2,3,4.
- Full with simultaneous push/pop: at count=4, push sel=9 with out_ready=1 -> count stays 4, drop=0, head advances to the next entry, and sel=9 later appears last.
- Wrap-around sweep: push sel=1..15 one per cycle with out_ready=1 held -> every entry emerges in order one cycle after push, count never exceeds 1, op_seen=16'hFFFE.
- Reset mid-operation: rst asserted with count=3 and in_valid=1 -> next cycle count=0, out_valid=0, drop=0, op_seen=0.
  - The first push after reset appears as head.
